// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the function-code constants and the per-register step function that
// yields a register's next value together with its wrap condition.
package regfile_pkg;

    localparam int unsigned FS_W  = 3;
    localparam int unsigned MAX_W = 32;

    localparam logic [FS_W-1:0] FS_HOLD = 3'b000;
    localparam logic [FS_W-1:0] FS_CLR  = 3'b001;
    localparam logic [FS_W-1:0] FS_LOAD = 3'b010;
    localparam logic [FS_W-1:0] FS_INC  = 3'b011;
    localparam logic [FS_W-1:0] FS_DEC  = 3'b100;
    localparam logic [FS_W-1:0] FS_SHL  = 3'b101;
    localparam logic [FS_W-1:0] FS_SHR  = 3'b110;
    localparam logic [FS_W-1:0] FS_ROL  = 3'b111;

    typedef struct packed {
        logic [MAX_W-1:0] next;
        logic             wrap;
    } step_t;

    // Operates on values zero-extended to MAX_W; w is the real register width.
    // The result is masked back to w bits so carries/shifts never leak upward.
    function automatic step_t reg_step(input logic [MAX_W-1:0] val,
                                       input logic [FS_W-1:0]  fun_sel,
                                       input logic [MAX_W-1:0] din,
                                       input int unsigned      w);
        step_t            s;
        logic [MAX_W-1:0] mask;
        logic             msb;
        mask   = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        msb    = |(val & (MAX_W'(1) << (w - 1)));
        s.next = val;
        s.wrap = 1'b0;
        case (fun_sel)
            FS_HOLD: s.next = val;
            FS_CLR:  s.next = '0;
            FS_LOAD: s.next = din;
            FS_INC: begin
                s.next = val + MAX_W'(1);
                s.wrap = (val == mask);
            end
            FS_DEC: begin
                s.next = val - MAX_W'(1);
                s.wrap = (val == '0);
            end
            FS_SHL: begin
                s.next = {val[MAX_W-2:0], 1'b0};
                s.wrap = msb;
            end
            FS_SHR: begin
                s.next = val >> 1;
                s.wrap = val[0];
            end
            FS_ROL: begin
                s.next = {val[MAX_W-2:0], msb};
                s.wrap = msb;
            end
        endcase
        s.next = s.next & mask;
        return s;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file.
// master: drives I, FunSel, RSel, O1Sel, O2Sel, FlagClr; receives O1, O2, Wrap.
// slave : the register file side.
interface param_reg_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned W    = 8
);
    localparam int unsigned SelW = $clog2(NREG);

    logic [W-1:0]    I;
    logic [FS_W-1:0] FunSel;
    logic [NREG-1:0] RSel;
    logic [SelW-1:0] O1Sel;
    logic [SelW-1:0] O2Sel;
    logic [NREG-1:0] FlagClr;
    logic [W-1:0]    O1;
    logic [W-1:0]    O2;
    logic [NREG-1:0] Wrap;

    modport master (
        output I, FunSel, RSel, O1Sel, O2Sel, FlagClr,
        input  O1, O2, Wrap
    );

    modport slave (
        input  I, FunSel, RSel, O1Sel, O2Sel, FlagClr,
        output O1, O2, Wrap
    );
endinterface

// File: rtl/reg_cell.sv
// One register of the file plus its sticky wrap flag.
// Ports: CLK, RST_N (async active-low), En (register selected), FunSel,
// I (load data), FlagClr (sync flag clear), Q (current value),
// Next (value after the coming edge), Wrap (sticky flag).
module reg_cell
    import regfile_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            En,
    input  logic [FS_W-1:0] FunSel,
    input  logic [W-1:0]    I,
    input  logic            FlagClr,
    output logic [W-1:0]    Q,
    output logic [W-1:0]    Next,
    output logic            Wrap
);
    step_t        step;
    logic [W-1:0] q_q;
    logic         wrap_q;

    always_comb begin
        step = reg_step(MAX_W'(q_q), FunSel, MAX_W'(I), W);
    end

    // Upper bits are masked to zero by reg_step.
    if (W < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^step.next[MAX_W-1:W];
    end

    assign Next = En ? step.next[W-1:0] : q_q;
    assign Q    = q_q;
    assign Wrap = wrap_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q <= Next;
            // A new wrap event outranks any clear in the same cycle.
            if (En && step.wrap) begin
                wrap_q <= 1'b1;
            end else if ((En && FunSel == FS_CLR) || FlagClr) begin
                wrap_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: NREG registers of W bits, one shared function
// per clock applied to every register whose RSel bit is set, sticky per-register
// wrap flags, two combinational read ports.
// Ports: CLK, RST_N (async active-low), bus (param_reg_file_if.slave:
// I, FunSel, RSel, O1Sel, O2Sel, FlagClr in; O1, O2, Wrap out).
// BYPASS=1 makes a read of a register being written show its next value.
module param_reg_file
    import regfile_pkg::*;
#(
    parameter int unsigned NREG   = 4,
    parameter int unsigned W      = 8,
    parameter bit          BYPASS = 1'b0
) (
    input logic             CLK,
    input logic             RST_N,
    param_reg_file_if.slave bus
);
    localparam int unsigned SelW = $clog2(NREG);

    logic [W-1:0]    q   [NREG];
    logic [W-1:0]    nxt [NREG];
    logic [W-1:0]    rd  [NREG];
    logic [NREG-1:0] wrap;
    logic [W-1:0]    o1;
    logic [W-1:0]    o2;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        reg_cell #(
            .W(W)
        ) u_cell (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .En     (bus.RSel[g]),
            .FunSel (bus.FunSel),
            .I      (bus.I),
            .FlagClr(bus.FlagClr[g]),
            .Q      (q[g]),
            .Next   (nxt[g]),
            .Wrap   (wrap[g])
        );

        assign rd[g] = (BYPASS && bus.RSel[g] && bus.FunSel != FS_HOLD) ? nxt[g] : q[g];
    end

    // Indices with no matching register (non-power-of-two NREG) read as 0.
    always_comb begin
        o1 = '0;
        o2 = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (bus.O1Sel == SelW'(k)) o1 = rd[k];
            if (bus.O2Sel == SelW'(k)) o2 = rd[k];
        end
    end

    assign bus.O1   = o1;
    assign bus.O2   = o2;
    assign bus.Wrap = wrap;
endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: three instances (NREG=4 plain, NREG=4 bypass,
// NREG=3 plain) share one stimulus stream and are checked against an
// arithmetic reference model.
module tb_param_reg_file;

    logic CLK;
    logic RST_N;
    int   tests = 0;
    int   fails = 0;

    param_reg_file_if #(.NREG(4), .W(8)) ia ();
    param_reg_file_if #(.NREG(4), .W(8)) ib ();
    param_reg_file_if #(.NREG(3), .W(8)) ic ();

    param_reg_file #(.NREG(4), .W(8), .BYPASS(1'b0)) dut_a (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (ia.slave)
    );
    param_reg_file #(.NREG(4), .W(8), .BYPASS(1'b1)) dut_b (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (ib.slave)
    );
    param_reg_file #(.NREG(3), .W(8), .BYPASS(1'b0)) dut_c (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (ic.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Currently applied stimulus.
    logic [2:0] fs;
    logic [3:0] rsel;
    logic [3:0] fclr;
    logic [7:0] din;
    logic [1:0] s1;
    logic [1:0] s2;

    // Reference state: a/b share ma/fa, the 3-register instance uses mc/fc.
    int ma[4];
    bit fa[4];
    int mc[3];
    bit fc[3];

    typedef struct {
        logic [2:0] f;
        logic [3:0] r;
        logic [7:0] d;
        logic [3:0] c;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [3:0] ew;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [3:0] r, input logic [7:0] d,
                         input logic [3:0] c, input logic [1:0] a1, input logic [1:0] a2);
        fs = f; rsel = r; din = d; fclr = c; s1 = a1; s2 = a2;
        ia.FunSel = f; ia.RSel = r; ia.I = d; ia.FlagClr = c; ia.O1Sel = a1; ia.O2Sel = a2;
        ib.FunSel = f; ib.RSel = r; ib.I = d; ib.FlagClr = c; ib.O1Sel = a1; ib.O2Sel = a2;
        ic.FunSel = f; ic.RSel = r[2:0]; ic.I = d; ic.FlagClr = c[2:0];
        ic.O1Sel = a1; ic.O2Sel = a2;
    endtask

    // One register's behaviour written as plain arithmetic on an 8-bit value.
    function automatic void ref_op(input int v, input int f, input int d,
                                   output int nv, output bit wr);
        wr = 1'b0;
        case (f)
            0: nv = v;
            1: nv = 0;
            2: nv = d;
            3: begin nv = (v + 1) % 256;   wr = (v == 255); end
            4: begin nv = (v + 255) % 256; wr = (v == 0);   end
            5: begin nv = (v * 2) % 256;   wr = (v >= 128); end
            6: begin nv = v / 2;           wr = (v % 2 == 1); end
            default: begin nv = (v * 2) % 256 + v / 128; wr = (v >= 128); end
        endcase
    endfunction

    function automatic void upd(input int v, input bit f, input bit sel, input bit clr,
                                output int nv, output bit nf);
        int t;
        bit w;
        w  = 1'b0;
        nv = v;
        nf = f;
        if (sel) begin
            ref_op(v, int'(fs), int'(din), t, w);
            nv = t;
        end
        if (sel && w) nf = 1'b1;
        else if ((sel && fs == 3'd1) || clr) nf = 1'b0;
    endfunction

    function automatic int next_of(input int v, input bit sel);
        int nv;
        bit wr;
        if (!sel) return v;
        ref_op(v, int'(fs), int'(din), nv, wr);
        return nv;
    endfunction

    function automatic int rd_c(input int s);
        if (s >= 3) return 0;
        return mc[s];
    endfunction

    function automatic logic [3:0] wa();
        logic [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = fa[k];
        return w;
    endfunction

    function automatic logic [2:0] wc();
        logic [2:0] w;
        for (int k = 0; k < 3; k++) w[k] = fc[k];
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin ma[k] = 0; fa[k] = 1'b0; end
        for (int k = 0; k < 3; k++) begin mc[k] = 0; fc[k] = 1'b0; end
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int k = 0; k < 4; k++) upd(ma[k], fa[k], rsel[k], fclr[k], ma[k], fa[k]);
        for (int k = 0; k < 3; k++) upd(mc[k], fc[k], rsel[k], fclr[k], mc[k], fc[k]);
        #1;
    endtask

    initial begin
        // Directed sequence from reset: {FunSel, RSel, I, FlagClr, O1Sel, O2Sel, O1, O2, Wrap}
        tbl[0]  = '{3'd2, 4'b0001, 8'hAA, 4'b0000, 2'd0, 2'd0, 8'hAA, 8'hAA, 4'b0000};
        tbl[1]  = '{3'd2, 4'b0010, 8'hFF, 4'b0000, 2'd1, 2'd0, 8'hFF, 8'hAA, 4'b0000};
        tbl[2]  = '{3'd3, 4'b0010, 8'h00, 4'b0000, 2'd1, 2'd0, 8'h00, 8'hAA, 4'b0010};
        tbl[3]  = '{3'd3, 4'b0010, 8'h00, 4'b0000, 2'd1, 2'd0, 8'h01, 8'hAA, 4'b0010};
        tbl[4]  = '{3'd0, 4'b0000, 8'h00, 4'b0010, 2'd1, 2'd0, 8'h01, 8'hAA, 4'b0000};
        tbl[5]  = '{3'd4, 4'b0100, 8'h00, 4'b0100, 2'd2, 2'd1, 8'hFF, 8'h01, 4'b0100};
        tbl[6]  = '{3'd2, 4'b0001, 8'h81, 4'b0000, 2'd0, 2'd3, 8'h81, 8'h00, 4'b0100};
        tbl[7]  = '{3'd2, 4'b1000, 8'h01, 4'b0000, 2'd0, 2'd3, 8'h81, 8'h01, 4'b0100};
        tbl[8]  = '{3'd7, 4'b1001, 8'h00, 4'b0000, 2'd0, 2'd3, 8'h03, 8'h02, 4'b0101};
        tbl[9]  = '{3'd6, 4'b1001, 8'h00, 4'b0000, 2'd0, 2'd3, 8'h01, 8'h01, 4'b0101};
        tbl[10] = '{3'd1, 4'b0100, 8'h00, 4'b0000, 2'd2, 2'd0, 8'h00, 8'h01, 4'b0001};
        tbl[11] = '{3'd5, 4'b0001, 8'h00, 4'b0000, 2'd0, 2'd3, 8'h02, 8'h01, 4'b0001};

        // Power-on reset.
        RST_N = 1'b0;
        drive(3'd0, 4'b0000, 8'h00, 4'b0000, 2'd0, 2'd1);
        model_reset();
        #12;
        check("reset_o1", 32'(ia.O1), 32'h0);
        check("reset_o2", 32'(ia.O2), 32'h0);
        check("reset_wrap", 32'(ia.Wrap), 32'h0);
        RST_N = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].f, tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].a1, tbl[i].a2);
            tick();
            drive(3'd0, 4'b0000, 8'h00, 4'b0000, tbl[i].a1, tbl[i].a2);
            #1;
            check($sformatf("tbl%0d_a_o1", i), 32'(ia.O1), 32'(tbl[i].e1));
            check($sformatf("tbl%0d_a_o2", i), 32'(ia.O2), 32'(tbl[i].e2));
            check($sformatf("tbl%0d_a_wrap", i), 32'(ia.Wrap), 32'(tbl[i].ew));
            check($sformatf("tbl%0d_b_o1", i), 32'(ib.O1), 32'(tbl[i].e1));
            check($sformatf("tbl%0d_b_o2", i), 32'(ib.O2), 32'(tbl[i].e2));
            check($sformatf("tbl%0d_b_wrap", i), 32'(ib.Wrap), 32'(tbl[i].ew));
        end

        // Asynchronous reset in the middle of a cycle while an increment is pending.
        drive(3'd3, 4'b1001, 8'h00, 4'b0000, 2'd0, 2'd3);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_o1", 32'(ia.O1), 32'h0);
        check("midrst_o2", 32'(ia.O2), 32'h0);
        check("midrst_wrap", 32'(ia.Wrap), 32'h0);
        check("midrst_wrap_c", 32'(ic.Wrap), 32'h0);
        drive(3'd0, 4'b0000, 8'h00, 4'b0000, 2'd0, 2'd3);
        model_reset();
        #2;
        RST_N = 1'b1;

        // Bypass: next value visible before the edge only on the BYPASS instance.
        drive(3'd2, 4'b0100, 8'h10, 4'b0000, 2'd2, 2'd2);
        tick();
        drive(3'd3, 4'b0100, 8'h00, 4'b0000, 2'd2, 2'd2);
        #1;
        check("byp_pre_b_o1", 32'(ib.O1), 32'h11);
        check("byp_pre_b_o2", 32'(ib.O2), 32'h11);
        check("byp_pre_a_o1", 32'(ia.O1), 32'h10);
        tick();
        drive(3'd0, 4'b0000, 8'h00, 4'b0000, 2'd2, 2'd2);
        #1;
        check("byp_post_b_o1", 32'(ib.O1), 32'h11);
        check("byp_post_b_o2", 32'(ib.O2), 32'h11);
        check("byp_post_a_o1", 32'(ia.O1), 32'h11);

        // NREG=3: out-of-range read port and five hold cycles with all selected.
        drive(3'd2, 4'b0111, 8'hC3, 4'b0000, 2'd0, 2'd3);
        tick();
        drive(3'd7, 4'b0001, 8'h00, 4'b0000, 2'd0, 2'd3);
        tick();
        drive(3'd0, 4'b1111, 8'h5A, 4'b0000, 2'd0, 2'd3);
        repeat (5) tick();
        check("n3_r0_hold", 32'(ic.O1), 32'h87);
        check("n3_oor", 32'(ic.O2), 32'h0);
        check("n3_wrap_hold", 32'(ic.Wrap), 32'h1);
        drive(3'd0, 4'b1111, 8'h5A, 4'b0000, 2'd2, 2'd3);
        #1;
        check("n3_r2_hold", 32'(ic.O1), 32'hC3);

        // Randomized stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            logic [3:0] c;
            case ($urandom_range(0, 3))
                0: d = 8'hFF;
                1: d = 8'h00;
                default: d = 8'($urandom);
            endcase
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            drive(3'($urandom_range(0, 7)), 4'($urandom), d, c,
                  2'($urandom), 2'($urandom));
            #1;
            check("rnd_a_o1", 32'(ia.O1), 32'(ma[s1]));
            check("rnd_a_o2", 32'(ia.O2), 32'(ma[s2]));
            check("rnd_b_o1", 32'(ib.O1), 32'(next_of(ma[s1], rsel[s1])));
            check("rnd_b_o2", 32'(ib.O2), 32'(next_of(ma[s2], rsel[s2])));
            check("rnd_c_o1", 32'(ic.O1), 32'(rd_c(int'(s1))));
            check("rnd_c_o2", 32'(ic.O2), 32'(rd_c(int'(s2))));
            tick();
            check("rnd_a_wrap", 32'(ia.Wrap), 32'(wa()));
            check("rnd_b_wrap", 32'(ib.Wrap), 32'(wa()));
            check("rnd_c_wrap", 32'(ic.Wrap), 32'(wc()));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
